// File: rtl/matmul_compute_if.sv
// AXI-Stream style output channel carrying signed C elements from the compute stage.
interface matmul_compute_if #(
    parameter int OUTW = 27
);
    logic [OUTW-1:0] tdata;
    logic            tvalid;
    logic            tlast;
    logic            tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/matmul_compute.sv
// Matrix-multiply compute stage: walks A/B memory read ports, accumulates each C[m][n]
// with a signed MAC and streams C row-major on the output channel.
module matmul_compute #(
    parameter int INW         = 12,
    parameter int OUTW        = 27,
    parameter int M           = 7,
    parameter int N           = 9,
    parameter int MAXK        = 8,
    parameter int K_BITS      = $clog2(MAXK + 1),
    parameter int A_ADDR_BITS = $clog2(M * MAXK),
    parameter int B_ADDR_BITS = $clog2(MAXK * N)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          matrices_loaded,
    input  logic [K_BITS-1:0]             K,
    output logic                          compute_finished,
    output logic [A_ADDR_BITS-1:0]        A_read_addr,
    input  logic signed [INW-1:0]         A_data,
    output logic [B_ADDR_BITS-1:0]        B_read_addr,
    input  logic signed [INW-1:0]         B_data,
    matmul_compute_if.master              axis_out
);
    localparam int MB = $clog2(M + 1);
    localparam int NB = $clog2(N + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACC   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;

    logic [2:0]              state_q, state_d;
    logic [MB-1:0]           m_q, m_d;
    logic [NB-1:0]           n_q, n_d;
    logic [K_BITS-1:0]       k_q, k_d;
    logic [K_BITS-1:0]       klat_q, klat_d;
    logic [A_ADDR_BITS-1:0]  a_base_q, a_base_d;
    logic [A_ADDR_BITS-1:0]  a_addr_q, a_addr_d;
    logic [B_ADDR_BITS-1:0]  b_addr_q, b_addr_d;
    logic                    vld_q, vld_d;
    logic                    first_q, first_d;
    logic signed [OUTW-1:0]  acc_q, acc_d;

    logic signed [2*INW-1:0] prod;
    logic signed [OUTW-1:0]  prod_ext;
    logic                    is_last;
    logic                    k_last;

    assign prod     = A_data * B_data;
    assign prod_ext = {{(OUTW - 2*INW){prod[2*INW-1]}}, prod};
    assign is_last  = (m_q == MB'(M - 1)) && (n_q == NB'(N - 1));
    assign k_last   = (k_q + K_BITS'(1)) == klat_q;

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        n_d      = n_q;
        k_d      = k_q;
        klat_d   = klat_q;
        a_base_d = a_base_q;
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        acc_d    = acc_q;
        // Flags follow each issued k by one cycle to line up with the memory data.
        vld_d    = (state_q == S_ACC);
        first_d  = (state_q == S_ACC) && (k_q == '0);

        if (vld_q) begin
            acc_d = first_q ? prod_ext : acc_q + prod_ext;
        end

        case (state_q)
            S_IDLE: begin
                if (matrices_loaded) begin
                    klat_d   = K;
                    m_d      = '0;
                    n_d      = '0;
                    k_d      = '0;
                    a_base_d = '0;
                    a_addr_d = '0;
                    b_addr_d = '0;
                    if (K == '0) begin
                        state_d = S_OUT;
                        acc_d   = '0;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                k_d      = k_q + K_BITS'(1);
                a_addr_d = a_addr_q + A_ADDR_BITS'(1);
                b_addr_d = b_addr_q + B_ADDR_BITS'(N);
                if (k_last) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_OUT;
            S_OUT: begin
                if (axis_out.tready) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        k_d = '0;
                        if (n_q == NB'(N - 1)) begin
                            n_d      = '0;
                            m_d      = m_q + MB'(1);
                            a_base_d = a_base_q + A_ADDR_BITS'(klat_q);
                            a_addr_d = a_base_q + A_ADDR_BITS'(klat_q);
                            b_addr_d = '0;
                        end else begin
                            n_d      = n_q + NB'(1);
                            a_addr_d = a_base_q;
                            b_addr_d = B_ADDR_BITS'(n_q) + B_ADDR_BITS'(1);
                        end
                        if (klat_q == '0) begin
                            acc_d = '0;
                        end else begin
                            state_d = S_ACC;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_WAIT;
            S_WAIT:  if (!matrices_loaded) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            klat_q   <= '0;
            a_base_q <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            vld_q    <= 1'b0;
            first_q  <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            n_q      <= n_d;
            k_q      <= k_d;
            klat_q   <= klat_d;
            a_base_q <= a_base_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            vld_q    <= vld_d;
            first_q  <= first_d;
            acc_q    <= acc_d;
        end
    end

    assign A_read_addr      = a_addr_q;
    assign B_read_addr      = b_addr_q;
    assign compute_finished = (state_q == S_DONE);
    assign axis_out.tvalid  = (state_q == S_OUT);
    assign axis_out.tlast   = (state_q == S_OUT) && is_last;
    assign axis_out.tdata   = acc_q;
endmodule

// File: tb/tb_matmul_compute.sv
// Scoreboard bench: a 2x2 (MAXK=4) instance and a default 7x9 (MAXK=8) instance
// share clock/reset; expected C streams are queued per instance and checked by a monitor.
module tb_matmul_compute;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [1:0]           loaded_r;
    logic [1:0]           tready_r;
    logic [1:0][3:0]      k_in;
    logic [1:0]           tvalid_w, tlast_w, fin_w;
    logic [1:0][26:0]     tdata_w;
    logic [1:0][6:0]      aaddr_w, baddr_w;
    logic signed [11:0]   memA [2][72];
    logic signed [11:0]   memB [2][72];

    typedef struct {
        logic signed [26:0] data;
        bit                 last;
    } exp_t;
    exp_t sbq [2][$];

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          hs_cnt [2];
    int          fin_cnt [2];
    int          last_hs [2];
    int          gap_chk [2];
    logic        prev_stall [2];
    logic [26:0] prev_data [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int GM    = (gi == 0) ? 2 : 7;
            localparam int GN    = (gi == 0) ? 2 : 9;
            localparam int GMAXK = (gi == 0) ? 4 : 8;
            localparam int KB    = $clog2(GMAXK + 1);
            localparam int AB    = $clog2(GM * GMAXK);
            localparam int BB    = $clog2(GMAXK * GN);

            logic [KB-1:0]      k_loc;
            logic [AB-1:0]      a_addr;
            logic [BB-1:0]      b_addr;
            logic signed [11:0] a_data, b_data;
            logic               fin;

            matmul_compute_if #(.OUTW(27)) axis ();

            matmul_compute #(
                .INW(12), .OUTW(27), .M(GM), .N(GN), .MAXK(GMAXK)
            ) dut (
                .clk(clk),
                .reset(rst),
                .matrices_loaded(loaded_r[gi]),
                .K(k_loc),
                .compute_finished(fin),
                .A_read_addr(a_addr),
                .A_data(a_data),
                .B_read_addr(b_addr),
                .B_data(b_data),
                .axis_out(axis.master)
            );

            always @(posedge clk) begin
                a_data <= memA[gi][int'(a_addr)];
                b_data <= memB[gi][int'(b_addr)];
            end

            assign k_loc        = KB'(k_in[gi]);
            assign axis.tready  = tready_r[gi];
            assign tvalid_w[gi] = axis.tvalid;
            assign tlast_w[gi]  = axis.tlast;
            assign tdata_w[gi]  = axis.tdata;
            assign fin_w[gi]    = fin;
            assign aaddr_w[gi]  = 7'(a_addr);
            assign baddr_w[gi]  = 7'(b_addr);
        end
    endgenerate

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input longint v, input bit last);
        exp_t e;
        e.data = 27'(v);
        e.last = last;
        sbq[d].push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    prev_stall[d] = 1'b0;
                    continue;
                end
                if (fin_w[d]) fin_cnt[d]++;
                if (prev_stall[d]) begin
                    chk("hold_valid", longint'(tvalid_w[d]), 1);
                    chk("hold_data", longint'(tdata_w[d]), longint'(prev_data[d]));
                end
                if (tvalid_w[d] && tready_r[d]) begin
                    if (sbq[d].size() == 0) begin
                        chk("extra_output_count", 1, 0);
                    end else begin
                        e = sbq[d].pop_front();
                        $display("[TB] dut%0d elem %0d tdata=%0d tlast=%0d", d, hs_cnt[d],
                                 $signed(tdata_w[d]), tlast_w[d]);
                        chk("tdata", longint'($signed(tdata_w[d])), longint'(e.data));
                        chk("tlast", longint'(tlast_w[d]), longint'(e.last));
                    end
                    if (gap_chk[d] != 0 && hs_cnt[d] > 0)
                        chk("elem_spacing", cyc - last_hs[d], gap_chk[d]);
                    last_hs[d] = cyc;
                    hs_cnt[d]++;
                end
                prev_stall[d] = tvalid_w[d] && !tready_r[d];
                prev_data[d]  = tdata_w[d];
            end
        end
    endtask

    task automatic run_frame(input int d, input int kval, input int stall_elem,
                             input int stall_len, input int gap);
        int f0;
        int left;
        int budget;
        int vcnt;
        f0         = fin_cnt[d];
        left       = stall_len;
        budget     = 0;
        vcnt       = 0;
        hs_cnt[d]  = 0;
        gap_chk[d] = gap;
        k_in[d]    = 4'(kval);
        tready_r[d] = 1'b1;
        loaded_r[d] = 1'b1;
        while (fin_cnt[d] == f0 && budget < 3000) begin
            tick();
            budget++;
            if (tvalid_w[d] && hs_cnt[d] == stall_elem && left > 0) begin
                tready_r[d] = 1'b0;
                left--;
            end else begin
                tready_r[d] = 1'b1;
            end
        end
        chk("frame_within_budget", longint'(budget < 3000), 1);
        // Loaded held high after completion must not trigger a second pass.
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tvalid_w[d]) vcnt++;
        end
        chk("no_restart_while_loaded", vcnt, 0);
        loaded_r[d] = 1'b0;
        repeat (3) tick();
        chk("finished_pulses", fin_cnt[d] - f0, 1);
        chk("queue_drained", sbq[d].size(), 0);
        gap_chk[d] = 0;
    endtask

    task automatic load_2x2();
        for (int i = 0; i < 72; i++) begin
            memA[0][i] = 12'sd0;
            memB[0][i] = 12'sd0;
        end
        memA[0][0] = 12'sd1; memA[0][1] = 12'sd2; memA[0][2] = 12'sd3; memA[0][3] = 12'sd4;
        memB[0][0] = 12'sd5; memB[0][1] = 12'sd6; memB[0][2] = 12'sd7; memB[0][3] = 12'sd8;
    endtask

    task automatic push_2x2();
        push(0, 19, 1'b0);
        push(0, 22, 1'b0);
        push(0, 43, 1'b0);
        push(0, 50, 1'b1);
    endtask

    task automatic stimulus();
        int f0;
        int budget;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk("reset_tvalid", longint'(tvalid_w[d]), 0);
            chk("reset_tlast", longint'(tlast_w[d]), 0);
            chk("reset_tdata", longint'(tdata_w[d]), 0);
            chk("reset_finished", longint'(fin_w[d]), 0);
            chk("reset_a_addr", longint'(aaddr_w[d]), 0);
            chk("reset_b_addr", longint'(baddr_w[d]), 0);
        end
        rst = 1'b0;
        tick();

        // 2x2, K=2, free-flowing output
        load_2x2();
        push_2x2();
        run_frame(0, 2, -1, 0, 4);

        // Same matrices, consumer stalls 5 cycles on the second element
        push_2x2();
        run_frame(0, 2, 1, 5, 0);

        // K=3 with distinct values so any address slip changes the sums
        for (int i = 0; i < 6; i++) begin
            memA[0][i] = 12'(i + 1);
            memB[0][i] = 12'(i + 1);
        end
        memA[0][6] = 12'sd100; memA[0][7] = 12'sd100;
        memB[0][6] = 12'sd100; memB[0][7] = 12'sd100;
        push(0, 22, 1'b0);
        push(0, 28, 1'b0);
        push(0, 49, 1'b0);
        push(0, 64, 1'b1);
        run_frame(0, 3, -1, 0, 5);

        // Reset while accumulating the second element, then full restart
        load_2x2();
        push_2x2();
        f0          = fin_cnt[0];
        hs_cnt[0]   = 0;
        k_in[0]     = 4'd2;
        tready_r[0] = 1'b1;
        loaded_r[0] = 1'b1;
        budget      = 0;
        while (hs_cnt[0] < 1 && budget < 100) begin
            tick();
            budget++;
        end
        chk("first_elem_before_abort", longint'(budget < 100), 1);
        tick();
        rst         = 1'b1;
        loaded_r[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("tvalid_in_reset", longint'(tvalid_w[0]), 0);
        end
        sbq[0].delete();
        rst = 1'b0;
        tick();
        chk("finished_after_abort", fin_cnt[0] - f0, 0);
        push_2x2();
        run_frame(0, 2, -1, 0, 4);

        // Default geometry, extreme negative operands
        for (int i = 0; i < 72; i++) begin
            memA[1][i] = -12'sd2048;
            memB[1][i] = -12'sd2048;
        end
        for (int i = 0; i < 63; i++) push(1, 33554432, i == 62);
        run_frame(1, 8, -1, 0, 10);

        for (int i = 0; i < 72; i++) memB[1][i] = 12'sd2047;
        for (int i = 0; i < 63; i++) push(1, -33538048, i == 62);
        run_frame(1, 8, -1, 0, 10);

        // K=0: every element is zero
        for (int i = 0; i < 63; i++) push(1, 0, i == 62);
        run_frame(1, 0, -1, 0, 0);
    endtask

    initial begin
        rst      = 1'b1;
        loaded_r = '0;
        tready_r = 2'b11;
        k_in     = '0;
        for (int d = 0; d < 2; d++) begin
            hs_cnt[d]     = 0;
            fin_cnt[d]    = 0;
            last_hs[d]    = 0;
            gap_chk[d]    = 0;
            prev_stall[d] = 1'b0;
            prev_data[d]  = '0;
            for (int i = 0; i < 72; i++) begin
                memA[d][i] = 12'sd0;
                memB[d][i] = 12'sd0;
            end
        end
        fork
            monitor();
            stimulus();
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/matmul_compute.md
Name: matmul_compute

Overview:
Compute stage directly downstream of the input matrix memories in the matrix-multiply accelerator. Once A (M×K) and B (K×N) are marked loaded, it walks the read ports of both memories and forms each C[m][n] = Σk A[m][k]·B[k][n] with a signed multiply-accumulate. It streams C row-major on an AXI-Stream master, then pulses compute_finished so the memories return to loading.

Parameters:
INW, 12, signed input element width
OUTW, 27, signed output width (2·INW + clog2(MAXK))
M, 7, rows of A and C
N, 9, columns of B and C
MAXK, 8, max inner dimension; K_BITS = clog2(MAXK+1), A_ADDR_BITS = clog2(M·MAXK), B_ADDR_BITS = clog2(MAXK·N)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
matrices_loaded  in  1  A/B valid in memories, K valid
K  in  K_BITS  inner dimension, sampled on leaving IDLE
compute_finished  out  1  one-cycle pulse after last C element accepted
A_read_addr  out  A_ADDR_BITS  A memory read address
A_data  in  INW  signed A element, valid 1 cycle after address
B_read_addr  out  B_ADDR_BITS  B memory read address
B_data  in  INW  signed B element, valid 1 cycle after address
AXIS_OUT_TDATA  out  OUTW  signed C element
AXIS_OUT_TVALID  out  1  output valid
AXIS_OUT_TLAST  out  1  high with C[M-1][N-1]
AXIS_OUT_TREADY  in  1  consumer ready

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high. Reset forces state IDLE and clears all counters and the accumulator. Reset values: compute_finished=0, AXIS_OUT_TVALID=0, AXIS_OUT_TLAST=0, AXIS_OUT_TDATA=0, A_read_addr=0, B_read_addr=0. Reset mid-operation abandons the current computation with no output.
- Memory layout: A row-major, A addr = m·K + k. B row-major, B addr = k·N + n. Both are generated with running registers: A base += K per row, B addr += N per k. No multipliers in the address path.
- Read latency: data arrives exactly 1 cycle after the address. A pipelined valid/first flag tracks each issued k.
- States:
  - IDLE: wait for matrices_loaded=1. Then latch K, set m=n=0, go to ACC; if K==0 go to OUT with acc=0.
  - ACC: issue (m,k) and (k,n) addresses for k=0..K-1, one per cycle. Each returning product is sign-extended to OUTW. The first product loads acc; later products add. After the issue of k=K-1, go to DRAIN.
  - DRAIN: add the final product, go to OUT.
  - OUT: AXIS_OUT_TVALID=1, TDATA=acc, TLAST=(m==M-1 && n==N-1). TDATA and TLAST are held stable until TREADY. On handshake: if last element go to DONE; else advance n (wrap to 0 and m++ at N-1) and go to ACC (or stay in OUT with acc=0 when K==0). TVALID drops the cycle after handshake.
  - DONE: compute_finished=1 for exactly one cycle, then go to WAIT_CLR.
  - WAIT_CLR: stay until matrices_loaded=0, then go to IDLE. This prevents a double start.
- Arithmetic: product is 2·INW signed. Accumulation is modulo 2^OUTW (wraps, no saturation).
- Throughput: K+2 cycles per element with TREADY held high. Latency from matrices_loaded to first TVALID is K+2 cycles.
- K > MAXK is not permitted; behaviour is undefined. Changes to K or matrices_loaded outside IDLE and WAIT_CLR are ignored.

Test Plan:
- M=2,N=2,MAXK=4, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], TREADY=1 -> TDATA 19,22,43,50; TLAST only with 50; one compute_finished pulse; element spacing 4 cycles.
- Default params, K=8, all A=-2048, all B=-2048 -> all 63 outputs = 33554432; all A=-2048, all B=2047 -> all outputs = -33538048.
- K=2 case with TREADY low 5 cycles on 2nd element -> TDATA=22 and TVALID held stable, no element skipped or duplicated, same 4 values in order.
- K=0 with matrices_loaded=1 -> M·N outputs all 0, TLAST on last, compute_finished pulses.
- Address check with 1-cycle memory model, M=2,N=2,K=3 -> A addrs 0,1,2,0,1,2,3,4,5,3,4,5; B addrs 0,2,4,1,3,5,0,2,4,1,3,5.
- Assert reset during ACC of 2nd element, then reload and restart -> outputs idle during reset, full correct sequence after, exactly one compute_finished; matrices_loaded held high after DONE -> no restart until it drops.
